// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared defaults and one-shot state encoding for mod_counter_n
package cnt_pkg;

  localparam int CNT_WIDTH_DEF = 8;
  localparam int CNT_TERM_DEF  = 138;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } cnt_state_t;

endpackage

// File: rtl/mod_counter_n.sv
// rtl/mod_counter_n.sv - programmable modulo counter with free-run and one-shot modes
module mod_counter_n
  import cnt_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH_DEF,
  parameter int DEF_TERM = CNT_TERM_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             up,
  input  logic             mode,
  input  logic             start,
  input  logic             term_wr,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  cnt_state_t       state, state_nxt;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] ld_sat;
  logic             step_wrap;
  logic             wrap_nxt;
  logic             done_nxt;

  assign end_val = up ? term : '0;
  assign tc      = en & (cnt == end_val);
  assign busy    = (state == ST_RUN);
  assign ld_sat  = (ld_val > term) ? term : ld_val;

  // Out-of-range counts (TERM lowered underneath us) wrap immediately in either direction.
  always_comb begin
    step_val  = cnt;
    step_wrap = 1'b0;
    if (up) begin
      if (cnt >= term) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val = cnt + WIDTH'(1);
      end
    end else begin
      if ((cnt == '0) || (cnt > term)) begin
        step_val  = term;
        step_wrap = 1'b1;
      end else begin
        step_val = cnt - WIDTH'(1);
      end
    end
  end

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if (clr) begin
      cnt_nxt   = '0;
      state_nxt = ST_IDLE;
    end else if (ld) begin
      cnt_nxt = ld_sat;
    end else begin
      case (state)
        ST_RUN: begin
          if (en) begin
            if (cnt == end_val) begin
              state_nxt = ST_HOLD;
              done_nxt  = 1'b1;
            end else begin
              cnt_nxt  = step_val;
              wrap_nxt = step_wrap;
            end
          end
        end
        default: begin
          // Mode is only sampled here, at a start seen outside RUN.
          if (start && mode) begin
            cnt_nxt   = up ? '0 : term;
            state_nxt = ST_RUN;
          end else if (state == ST_HOLD) begin
            if (start) state_nxt = ST_IDLE;
          end else if (!mode && en) begin
            cnt_nxt  = step_val;
            wrap_nxt = step_wrap;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      term  <= WIDTH'(DEF_TERM);
      state <= ST_IDLE;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      state <= state_nxt;
      wrap  <= wrap_nxt;
      done  <= done_nxt;
      if (term_wr) term <= term_val;
    end
  end

endmodule

// File: tb/tb_mod_counter_n.sv
// tb/tb_mod_counter_n.sv - self-checking bench for mod_counter_n
module tb_mod_counter_n;

  logic       clk;
  logic       rst_n;
  logic       en, clr, ld, up, mode, start, term_wr;
  logic [7:0] ld_val, term_val;
  logic [7:0] cnt;
  logic       tc, wrap, busy, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       en, clr, ld;
    logic [7:0] ld_val;
    logic       up, mode, start, term_wr;
    logic [7:0] term_val;
    logic [7:0] e_cnt;
    logic       e_wrap, e_busy, e_done;
  } vec_t;

  int m_cnt, m_term;
  bit m_run, m_fin, m_wrap, m_done;

  mod_counter_n #(.WIDTH(8), .DEF_TERM(138)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ld(ld), .ld_val(ld_val),
    .up(up), .mode(mode), .start(start), .term_wr(term_wr), .term_val(term_val),
    .cnt(cnt), .tc(tc), .wrap(wrap), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk_in(input logic e, input logic c, input logic l, input logic [7:0] lv,
                                 input logic u, input logic m, input logic s, input logic tw,
                                 input logic [7:0] tv);
    vec_t v;
    v.en = e; v.clr = c; v.ld = l; v.ld_val = lv; v.up = u; v.mode = m; v.start = s;
    v.term_wr = tw; v.term_val = tv;
    v.e_cnt = '0; v.e_wrap = 1'b0; v.e_busy = 1'b0; v.e_done = 1'b0;
    return v;
  endfunction

  function automatic vec_t with_exp(input vec_t vi, input logic [7:0] c, input logic w,
                                    input logic b, input logic d);
    vec_t v;
    v = vi;
    v.e_cnt = c; v.e_wrap = w; v.e_busy = b; v.e_done = d;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_term = 138; m_run = 0; m_fin = 0; m_wrap = 0; m_done = 0;
  endtask

  // One modular step over 0..TERM; anything above TERM wraps at once.
  task automatic advance(input bit dir_up);
    if (m_cnt > m_term) begin
      m_cnt  = dir_up ? 0 : m_term;
      m_wrap = 1;
    end else if (dir_up) begin
      m_cnt  = (m_cnt + 1) % (m_term + 1);
      m_wrap = (m_cnt == 0);
    end else begin
      m_wrap = (m_cnt == 0);
      m_cnt  = (m_cnt + m_term) % (m_term + 1);
    end
  endtask

  task automatic model_step(input vec_t v);
    int nterm;
    int ev;
    nterm  = v.term_wr ? int'(v.term_val) : m_term;
    m_wrap = 0;
    m_done = 0;
    if (v.clr) begin
      m_cnt = 0; m_run = 0; m_fin = 0;
    end else if (v.ld) begin
      m_cnt = (int'(v.ld_val) > m_term) ? m_term : int'(v.ld_val);
    end else if (m_run) begin
      if (v.en) begin
        ev = v.up ? m_term : 0;
        if (m_cnt == ev) begin
          m_run = 0; m_fin = 1; m_done = 1;
        end else begin
          advance(v.up);
        end
      end
    end else if (v.start && v.mode) begin
      m_cnt = v.up ? 0 : m_term;
      m_run = 1;
      m_fin = 0;
    end else if (m_fin) begin
      if (v.start) m_fin = 0;
    end else if (!v.mode && v.en) begin
      advance(v.up);
    end
    m_term = nterm;
  endtask

  task automatic apply(input vec_t v);
    en = v.en; clr = v.clr; ld = v.ld; ld_val = v.ld_val; up = v.up; mode = v.mode;
    start = v.start; term_wr = v.term_wr; term_val = v.term_val;
    model_step(v);
    @(posedge clk);
    #1;
    check("model_cnt", 32'(cnt), 32'(m_cnt));
    check("model_wrap", 32'(wrap), 32'(m_wrap));
    check("model_busy", 32'(busy), 32'(m_run));
    check("model_done", 32'(done), 32'(m_done));
    check("model_tc", 32'(tc), 32'(v.en && (m_cnt == (v.up ? m_term : 0))));
  endtask

  task automatic idle_inputs();
    en = 0; clr = 0; ld = 0; ld_val = 0; up = 1; mode = 0; start = 0; term_wr = 0; term_val = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_cnt", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;
  endtask

  vec_t tbl[13];
  vec_t v;
  int   wrap_at[$];
  int   busy_cycles, done_cycles;
  bit   up_r, mode_r;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    do_reset();

    // Directed table from reset, TERM=138.
    tbl[0]  = with_exp(mk_in(1, 0, 0, 8'd0,   1, 0, 0, 0, 8'd0), 8'd1,   0, 0, 0);
    tbl[1]  = with_exp(mk_in(0, 0, 1, 8'd200, 1, 0, 0, 0, 8'd0), 8'd138, 0, 0, 0);
    tbl[2]  = with_exp(mk_in(1, 0, 0, 8'd0,   1, 0, 0, 0, 8'd0), 8'd0,   1, 0, 0);
    tbl[3]  = with_exp(mk_in(0, 0, 0, 8'd0,   1, 0, 0, 0, 8'd0), 8'd0,   0, 0, 0);
    tbl[4]  = with_exp(mk_in(1, 0, 0, 8'd0,   0, 0, 0, 0, 8'd0), 8'd138, 1, 0, 0);
    tbl[5]  = with_exp(mk_in(1, 0, 0, 8'd0,   0, 0, 0, 0, 8'd0), 8'd137, 0, 0, 0);
    tbl[6]  = with_exp(mk_in(0, 0, 0, 8'd0,   0, 0, 0, 1, 8'd9), 8'd137, 0, 0, 0);
    tbl[7]  = with_exp(mk_in(1, 0, 0, 8'd0,   0, 0, 0, 0, 8'd0), 8'd9,   1, 0, 0);
    tbl[8]  = with_exp(mk_in(0, 0, 0, 8'd0,   1, 1, 1, 0, 8'd0), 8'd0,   0, 1, 0);
    tbl[9]  = with_exp(mk_in(1, 0, 0, 8'd0,   1, 1, 1, 0, 8'd0), 8'd1,   0, 1, 0);
    tbl[10] = with_exp(mk_in(1, 1, 1, 8'd5,   1, 1, 0, 0, 8'd0), 8'd0,   0, 0, 0);
    tbl[11] = with_exp(mk_in(1, 0, 0, 8'd0,   0, 1, 1, 0, 8'd0), 8'd9,   0, 1, 0);
    tbl[12] = with_exp(mk_in(1, 0, 0, 8'd0,   0, 0, 0, 0, 8'd0), 8'd8,   0, 1, 0);
    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      check($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
      check($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].e_wrap));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
    end

    // Free-run up for 300 cycles: mod-139, wraps at cycles 139 and 278.
    do_reset();
    wrap_at.delete();
    for (int k = 1; k <= 300; k++) begin
      apply(mk_in(1, 0, 0, 8'd0, 1, 0, 0, 0, 8'd0));
      check("fr_cnt", 32'(cnt), 32'(k % 139));
      if (wrap) wrap_at.push_back(k);
    end
    check("fr_wrap_count", 32'(wrap_at.size()), 2);
    if (wrap_at.size() == 2) begin
      check("fr_wrap_first", 32'(wrap_at[0]), 139);
      check("fr_wrap_second", 32'(wrap_at[1]), 278);
    end

    // Down from reset: 0 -> 138 wraps, then decrements.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      apply(mk_in(1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd0));
      check("dn_cnt", 32'(cnt), 32'(k == 1 ? 138 : 139 - k));
      check("dn_wrap", 32'(wrap), 32'(k == 1));
    end

    // Lower TERM under a running count, then saturating load.
    do_reset();
    apply(mk_in(0, 0, 1, 8'd100, 1, 0, 0, 0, 8'd0));
    check("tl_load", 32'(cnt), 100);
    apply(mk_in(0, 0, 0, 8'd0, 1, 0, 0, 1, 8'd50));
    check("tl_hold", 32'(cnt), 100);
    apply(mk_in(1, 0, 0, 8'd0, 1, 0, 0, 0, 8'd0));
    check("tl_wrap_cnt", 32'(cnt), 0);
    check("tl_wrap", 32'(wrap), 1);
    apply(mk_in(0, 0, 1, 8'd200, 1, 0, 0, 0, 8'd0));
    check("tl_sat", 32'(cnt), 50);

    // One-shot with TERM=9.
    do_reset();
    apply(mk_in(0, 0, 0, 8'd0, 1, 1, 0, 1, 8'd9));
    apply(mk_in(1, 0, 0, 8'd0, 1, 1, 1, 0, 8'd0));
    busy_cycles = busy ? 1 : 0;
    done_cycles = 0;
    for (int k = 0; k < 15; k++) begin
      apply(mk_in(1, 0, 0, 8'd0, 1, 1, 0, 0, 8'd0));
      if (busy) busy_cycles++;
      if (done) done_cycles++;
    end
    check("os_busy_cycles", 32'(busy_cycles), 10);
    check("os_done_count", 32'(done_cycles), 1);
    check("os_hold_cnt", 32'(cnt), 9);
    check("os_hold_busy", 32'(busy), 0);

    // Reset mid-RUN at cnt=5, then clr+ld together.
    do_reset();
    apply(mk_in(0, 0, 0, 8'd0, 1, 1, 0, 1, 8'd9));
    apply(mk_in(0, 0, 0, 8'd0, 1, 1, 1, 0, 8'd0));
    for (int k = 0; k < 5; k++) apply(mk_in(1, 0, 0, 8'd0, 1, 1, 0, 0, 8'd0));
    check("ar_pre_cnt", 32'(cnt), 5);
    check("ar_pre_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_cnt", 32'(cnt), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_done", 32'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      apply(mk_in(1, 0, 0, 8'd0, 1, 1, 0, 0, 8'd0));
      if (done) done_cycles++;
    end
    check("ar_no_done", 32'(done_cycles), 0);
    check("ar_idle_cnt", 32'(cnt), 0);
    apply(mk_in(1, 0, 1, 8'd7, 1, 0, 0, 0, 8'd0));
    apply(mk_in(1, 1, 1, 8'd7, 1, 0, 0, 0, 8'd0));
    check("clr_ld_cnt", 32'(cnt), 0);

    // en toggled during RUN.
    do_reset();
    apply(mk_in(0, 0, 0, 8'd0, 1, 1, 0, 1, 8'd9));
    apply(mk_in(0, 0, 0, 8'd0, 1, 1, 1, 0, 8'd0));
    for (int k = 0; k < 24; k++) begin
      apply(mk_in(logic'(k % 2), 0, 0, 8'd0, 1, 1, 0, 0, 8'd0));
      check("tg_tc", 32'(tc), 32'((k % 2 == 1) && (cnt == 8'd9)));
    end
    check("tg_final_cnt", 32'(cnt), 9);

    // Randomized traffic against the reference model.
    do_reset();
    up_r = 1; mode_r = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 19) == 0) up_r = ~up_r;
      if ($urandom_range(0, 29) == 0) mode_r = ~mode_r;
      v = mk_in($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 29) == 0, 8'($urandom), up_r, mode_r,
                $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 20)) : 8'($urandom));
      apply(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_counter_n.md
MOD_COUNTER_N -- requirements
Module: mod_counter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8: counter/data width, 2..16.
REQ-002 SHALL have parameter DEF_TERM, default 138: reset terminal value, DEF_TERM < 2**WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port clr  input  1  synchronous clear.
REQ-007 SHALL have port ld  input  1  synchronous load strobe.
REQ-008 SHALL have port ld_val  input  WIDTH  load value.
REQ-009 SHALL have port up  input  1  direction: 1 up, 0 down.
REQ-010 SHALL have port mode  input  1  0 free-run, 1 one-shot.
REQ-011 SHALL have port start  input  1  one-shot start pulse.
REQ-012 SHALL have port term_wr / term_val  input  1 / WIDTH  terminal-value write.
REQ-013 SHALL have port cnt  output  WIDTH  current count (registered).
REQ-014 SHALL have port tc  output  1  terminal-count flag (combinational from registers).
REQ-015 SHALL have port wrap  output  1  one-cycle pulse on wrap.
REQ-016 SHALL have ports busy / done  output  1 / 1  one-shot running / one-cycle completion pulse.

Function
REQ-017 SHALL count over range 0..TERM inclusive, TERM a register (modulus TERM+1); DEF_TERM=138 gives mod-139.
REQ-018 SHALL update TERM <= term_val on term_wr, effective next cycle; count in progress not altered.
REQ-019 SHALL define end value E = TERM when up=1, 0 when up=0; tc = en & (cnt == E).
REQ-020 SHALL apply priority per cycle: clr > ld > count; clr: cnt<=0, FSM->IDLE, no wrap/done.
REQ-021 SHALL on ld load min(ld_val, TERM); no wrap/done pulse on load.
REQ-022 SHALL, when counting up with cnt >= TERM, load 0 and pulse wrap (covers TERM lowered below cnt).
REQ-023 SHALL, when counting down with cnt == 0 or cnt > TERM, load TERM and pulse wrap.
REQ-024 SHALL, in free-run (mode=0), count one step per cycle with en=1, hold with en=0; FSM stays IDLE, busy=0, done=0.
REQ-025 SHALL implement one-shot FSM states IDLE, RUN, HOLD.
REQ-026 SHALL on start in IDLE with mode=1 load start value (0 if up, TERM if down), enter RUN, busy=1.
REQ-027 SHALL in RUN step on en; at cnt==E with en=1 stay at E (no wrap), enter HOLD, pulse done one cycle.
REQ-028 SHALL in HOLD keep cnt at E, busy=0; start restarts as in REQ-026, clr returns IDLE.
REQ-029 SHALL ignore start while RUN; ignore mode changes except when sampled at start in IDLE/HOLD.
REQ-030 SHALL hold cnt in IDLE with mode=1 (no counting without start).
REQ-031 SHALL give ld priority in RUN (cnt loaded, FSM stays RUN); simultaneous clr and start: clr wins.

Reset
REQ-032 SHALL on rst_n=0 asynchronously set cnt=0, TERM=DEF_TERM, FSM=IDLE, wrap=0, done=0, busy=0.
REQ-033 SHALL abort any one-shot on reset mid-RUN; no done pulse after release.
REQ-034 SHALL resume counting on first rising clk edge after rst_n deasserts.

Structure
REQ-035 SHALL place the FSM state enum (IDLE, RUN, HOLD) and default WIDTH/DEF_TERM constants in shared package cnt_pkg.
REQ-036 SHALL be a single module; no sub-module natural; no asynchronous load/clear path besides rst_n.

Verification
REQ-037 SHALL cover: defaults, up, en=1 free-run 300 cycles -> cnt 0..138,0..; wrap pulses at cycles 139 and 278; never 139.
REQ-038 SHALL cover: up=0 from reset -> cnt 0,138,137,...; wrap on 0->138.
REQ-039 SHALL cover: cnt=100, term_wr term_val=50 -> next up step gives cnt=0 with wrap; ld ld_val=200 -> cnt=50.
REQ-040 SHALL cover: mode=1, TERM=9, start, en=1 -> busy 10 cycles, cnt 0..9, done once, cnt holds 9, busy=0.
REQ-041 SHALL cover: rst_n low mid-RUN at cnt=5 -> cnt=0, busy=0, done stays 0; clr+ld same cycle -> cnt=0.
REQ-042 SHALL cover: en toggled 1/0 in RUN -> cnt advances only on en=1 cycles; tc only when en=1 and cnt==E.
